cordic_phase_sweep: RTL and testbench
=====================================

Name: cordic_phase_sweep

Overview:
- Upstream angle generator for the 31-stage pipelined `cordic` block.
- Issues a burst of `num_samples` angles, one per clock, in Q4.28 radians. Phase starts at 0 and advances by a fixed step, wrapping into [0, 2π).
- Carries a valid token through a delay line matched to the cordic latency, so downstream logic knows which cycles of sine/cosine correspond to issued angles.
- Signals completion when the last result emerges.

Parameters:
- WIDTH, 32, angle/step word width (signed fixed point).
- FPSHIFT, 28, fractional bits.
- LATENCY, 32, cordic latency in clocks: 31 update stages plus the output register.
- CNTW, 16, width of the sample counter.
- TWO_PI_FP, 1686629713, round(2π·2^FPSHIFT).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled in IDLE only.
- stop  input  1  abort issuing; in-flight samples still drain.
- step  input  WIDTH  phase increment (unsigned magnitude), latched on accepted start.
- num_samples  input  CNTW  number of angles to issue, latched on accepted start.
- angle  output  WIDTH  current angle, connected to cordic `angle`.
- angle_valid  output  1  `angle` is a sweep sample this cycle.
- out_valid  output  1  cordic sine/cosine this cycle belong to the sweep.
- sample_idx  output  CNTW  index of the sample on `angle` (0-based).
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at sweep completion.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async, rst=1): state=IDLE, angle=0, angle_valid=0, sample_idx=0, busy=0, done=0, err=0, valid delay line all 0, so out_valid=0. A reset mid-sweep discards all in-flight tokens; no done is produced.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and step ≥ TWO_PI_FP: start rejected, err=1 for one cycle, stay IDLE.
  - start=1 and num_samples=0: no angles issued, done=1 next cycle, stay IDLE.
  - Otherwise start=1: latch step and num_samples, go RUN.
- RUN:
  - The first RUN cycle presents angle=0, angle_valid=1, sample_idx=0.
  - Each following cycle: phase_next = phase + step, computed in WIDTH+1 bits. If phase_next ≥ TWO_PI_FP, subtract TWO_PI_FP. The angle is therefore always in [0, TWO_PI_FP).
  - sample_idx increments by one per issued sample.
  - After sample num_samples-1 is issued, go DRAIN; angle_valid=0 from the next cycle.
- stop=1 in RUN: the current cycle's sample is not issued (angle_valid=0 that cycle), go DRAIN. stop in IDLE or DRAIN has no effect. stop and start together in IDLE: start wins.
- DRAIN: angle holds its last value, angle_valid=0. Stay until the delay line is empty, then go IDLE.
- Delay line: a LATENCY-deep shift register of angle_valid; out_valid is its tail.
  - done=1 in the same cycle as the last out_valid=1 of the sweep.
  - If no sample was issued (immediate stop), done pulses the cycle DRAIN is entered, and the state returns to IDLE.
- start in RUN or DRAIN is ignored (no err).
- Latency: angle k appears k+1 cycles after the accepted start edge. The matching out_valid is LATENCY cycles later.
- step=0 is legal: a constant angle of 0 is issued.
- busy drops in the cycle after done.

Optional Feature:
- CORDIC_SWEEP_START_PHASE_EN adds an input `start_phase` of WIDTH bits, latched on accepted start.
- With the macro, the first angle equals start_phase. start is rejected with err if start_phase ≥ TWO_PI_FP or step ≥ TWO_PI_FP.
- Without the macro, there is no port and the first angle is always 0.

Test Plan:
- step=421657428 (π/2), num_samples=4 -> angle sequence 0, 421657428, 843314856, 1264972284 on consecutive cycles, with angle_valid high 4 cycles. out_valid is high 4 cycles starting 32 cycles after the first angle; done is coincident with the 4th out_valid.
- step=268435456 (1.0 rad), num_samples=8 -> angles k·2^28 for k=0..6, then the 8th angle is 192418479 (wrapped). The angle never reaches ≥1686629713.
- step=1686629713, start=1 -> err pulses 1 cycle, busy stays 0, no angle_valid.
- num_samples=100, stop asserted on the 10th RUN cycle -> exactly 9 angle_valid and 9 out_valid cycles; done pulses with the 9th out_valid; the state returns to IDLE.
- rst pulsed 20 cycles into a 50-sample sweep -> all outputs are 0 immediately (asynchronously), no out_valid or done follows, and a new start is accepted normally.
- num_samples=0 with start -> done pulses the next cycle; angle_valid, out_valid and busy stay 0.

Source files
------------

// File: rtl/cordic_phase_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cordic_phase_sweep
//  Description : Angle sweep generator feeding a 31-stage pipelined CORDIC.
//                Issues num_samples Q4.28 angles (one per clock) advancing by
//                a fixed step and wrapping into [0, 2*pi). A valid token rides
//                a delay line matched to the CORDIC latency so downstream
//                logic knows which sine/cosine results belong to the sweep.
//                Optional macro CORDIC_SWEEP_START_PHASE_EN adds a
//                start_phase input that seeds the first angle.
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_phase_sweep #(
   parameter int WIDTH     = 32,
   parameter int FPSHIFT   = 28,
   parameter int LATENCY   = 32,
   parameter int CNTW      = 16,
   parameter int TWO_PI_FP = 1686629713
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] step,
   input  logic [CNTW-1:0]  num_samples,
`ifdef CORDIC_SWEEP_START_PHASE_EN
   input  logic [WIDTH-1:0] start_phase,
`endif
   output logic [WIDTH-1:0] angle,
   output logic             angle_valid,
   output logic             out_valid,
   output logic [CNTW-1:0]  sample_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [WIDTH:0]     c_TWO_PI    = (WIDTH+1)'(TWO_PI_FP);
   localparam logic [WIDTH-1:0]   c_TWO_PI_W  = c_TWO_PI[WIDTH-1:0];
   localparam logic [CNTW-1:0]    c_ONE       = CNTW'(1);
   localparam logic [LATENCY-1:0] c_TAIL_ONLY = {1'b1, {(LATENCY-1){1'b0}}};

   // Parameter sanity: the fraction must fit inside the word, and the
   // tail-only detection of the delay line needs at least two stages.
   if (FPSHIFT >= WIDTH) begin : g_bad_fpshift
      $error("cordic_phase_sweep: FPSHIFT must be smaller than WIDTH");
   end
   if (LATENCY < 2) begin : g_bad_latency
      $error("cordic_phase_sweep: LATENCY must be at least 2");
   end

   state_t             r_state;
   logic [WIDTH-1:0]   r_angle;
   logic [WIDTH-1:0]   r_step;
   logic [CNTW-1:0]    r_num;
   logic [CNTW-1:0]    r_idx;
   logic               r_done;
   logic               r_err;
   logic [LATENCY-1:0] r_dly;

   logic               w_issue;
   logic [LATENCY-1:0] w_dly_next;
   logic [WIDTH:0]     w_sum;
   logic               w_wrap;
   logic [WIDTH-1:0]   w_phase_next;
   logic               w_last;
   logic               w_start_bad;
   logic [WIDTH-1:0]   w_first_angle;

   // A RUN cycle issues its sample unless stop is raised in that same cycle,
   // so the issue strobe is the one output that is not purely registered.
   assign w_issue    = (r_state == S_RUN) && !stop;
   assign w_dly_next = {r_dly[LATENCY-2:0], w_issue};

   // Phase accumulate in WIDTH+1 bits; both operands are below 2*pi, so a
   // single conditional subtraction keeps the result in [0, 2*pi). The low
   // WIDTH bits of the modular difference equal the true wrapped value.
   assign w_sum        = {1'b0, r_angle} + {1'b0, r_step};
   assign w_wrap       = (w_sum >= c_TWO_PI);
   assign w_phase_next = w_wrap ? (r_angle + r_step - c_TWO_PI_W)
                                : (r_angle + r_step);

   assign w_last = (r_idx == (r_num - c_ONE));

`ifdef CORDIC_SWEEP_START_PHASE_EN
   assign w_start_bad   = ({1'b0, step} >= c_TWO_PI) ||
                          ({1'b0, start_phase} >= c_TWO_PI);
   assign w_first_angle = start_phase;
`else
   assign w_start_bad   = ({1'b0, step} >= c_TWO_PI);
   assign w_first_angle = '0;
`endif

   // Valid token delay line matched to the CORDIC pipeline depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dly <= '0;
      end else begin
         r_dly <= w_dly_next;
      end
   end

   // Sweep control: start acceptance, phase accumulation, drain and done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_angle <= '0;
         r_step  <= '0;
         r_num   <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_start_bad) begin
                     r_err <= 1'b1;
                  end else if (num_samples == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_step  <= step;
                     r_num   <= num_samples;
                     r_angle <= w_first_angle;
                     r_idx   <= '0;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  // Nothing in flight means nothing will ever emerge, so
                  // completion is flagged on entry to DRAIN.
                  r_state <= S_DRAIN;
                  if (w_dly_next == '0) begin
                     r_done <= 1'b1;
                  end
               end else if (w_last) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_angle <= w_phase_next;
                  r_idx   <= r_idx + c_ONE;
               end
            end
            S_DRAIN: begin
               // Done lines up with the final token reaching the tail.
               if (w_dly_next == c_TAIL_ONLY) begin
                  r_done <= 1'b1;
               end
               if (r_dly[LATENCY-2:0] == '0) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign angle       = r_angle;
   assign angle_valid = w_issue;
   assign out_valid   = r_dly[LATENCY-1];
   assign sample_idx  = r_idx;
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_phase_sweep
//  Description : Directed self-checking bench for cordic_phase_sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_phase_sweep;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] step;
   logic [15:0] num_samples;
`ifdef CORDIC_SWEEP_START_PHASE_EN
   logic [31:0] start_phase;
`endif
   logic [31:0] angle;
   logic        angle_valid;
   logic        out_valid;
   logic [15:0] sample_idx;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   cordic_phase_sweep dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .step        (step),
      .num_samples (num_samples),
`ifdef CORDIC_SWEEP_START_PHASE_EN
      .start_phase (start_phase),
`endif
      .angle       (angle),
      .angle_valid (angle_valid),
      .out_valid   (out_valid),
      .sample_idx  (sample_idx),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Step until done, counting out_valid / angle_valid cycles on the way.
   task automatic run_out(input int bound, output int n_ov, output int n_av,
                          output bit got_done, output logic ov_at_done);
      n_ov = 0;
      n_av = 0;
      got_done = 1'b0;
      ov_at_done = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (out_valid) n_ov++;
         if (angle_valid) n_av++;
         if (done) begin
            got_done = 1'b1;
            ov_at_done = out_valid;
            break;
         end
         cyc();
      end
   endtask

   int          n_ov;
   int          n_av;
   bit          got_done;
   logic        ov_done;
   int          any_bad;
   logic [31:0] exp_ang [8];

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      step = '0;
      num_samples = '0;
`ifdef CORDIC_SWEEP_START_PHASE_EN
      start_phase = '0;
`endif
      #12;
      chk("reset_angle", angle, 0);
      chk("reset_angle_valid", angle_valid, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_idx", sample_idx, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // ---- pi/2 step, 4 samples ----
      start = 1'b1; step = 32'd421657428; num_samples = 16'd4;
      cyc();                                   // t=0, first RUN cycle
      start = 1'b0;
      chk("q_angle0", angle, 0);
      chk("q_valid0", angle_valid, 1);
      chk("q_idx0", sample_idx, 0);
      chk("q_busy", busy, 1);
      cyc();
      chk("q_angle1", angle, 421657428);
      cyc();
      chk("q_angle2", angle, 843314856);
      cyc();
      chk("q_angle3", angle, 1264972284);
      chk("q_idx3", sample_idx, 3);
      chk("q_valid3", angle_valid, 1);
      cyc();                                   // t=4, DRAIN
      chk("q_valid_off", angle_valid, 0);
      chk("q_angle_hold", angle, 1264972284);
      chk("q_busy_drain", busy, 1);
      repeat (27) cyc();                       // t=31
      chk("q_ov_before", out_valid, 0);
      cyc();                                   // t=32
      chk("q_ov_first", out_valid, 1);
      chk("q_done_early", done, 0);
      cyc(); cyc();                            // t=34
      chk("q_ov_third", out_valid, 1);
      cyc();                                   // t=35
      chk("q_ov_last", out_valid, 1);
      chk("q_done", done, 1);
      chk("q_busy_at_done", busy, 1);
      cyc();                                   // t=36
      chk("q_ov_after", out_valid, 0);
      chk("q_done_after", done, 0);
      chk("q_busy_after", busy, 0);

      // ---- 1.0 rad step, 8 samples, last one wraps ----
      exp_ang[0] = 32'd0;          exp_ang[1] = 32'd268435456;
      exp_ang[2] = 32'd536870912;  exp_ang[3] = 32'd805306368;
      exp_ang[4] = 32'd1073741824; exp_ang[5] = 32'd1342177280;
      exp_ang[6] = 32'd1610612736; exp_ang[7] = 32'd192418479;
      start = 1'b1; step = 32'd268435456; num_samples = 16'd8;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("r_angle%0d", k), angle, exp_ang[k]);
         chk($sformatf("r_idx%0d", k), sample_idx, k);
         cyc();
      end
      run_out(60, n_ov, n_av, got_done, ov_done);
      chk("r_done_seen", got_done, 1);
      chk("r_ov_count", n_ov, 8);
      chk("r_no_extra_av", n_av, 0);
      chk("r_ov_at_done", ov_done, 1);
      cyc();
      chk("r_busy_after", busy, 0);

      // ---- step equal to 2*pi is rejected ----
      start = 1'b1; step = 32'd1686629713; num_samples = 16'd5;
      cyc();
      start = 1'b0;
      chk("e_err", err, 1);
      chk("e_busy", busy, 0);
      chk("e_valid", angle_valid, 0);
      cyc();
      chk("e_err_pulse", err, 0);
      chk("e_busy2", busy, 0);

      // ---- largest legal step, wrap lands just below 2*pi ----
      start = 1'b1; step = 32'd1686629712; num_samples = 16'd3;
      cyc();
      start = 1'b0;
      chk("b_err", err, 0);
      chk("b_angle0", angle, 0);
      cyc();
      chk("b_angle1", angle, 1686629712);
      cyc();
      chk("b_angle2", angle, 1686629711);
      cyc();
      run_out(60, n_ov, n_av, got_done, ov_done);
      chk("b_done_seen", got_done, 1);
      chk("b_ov_count", n_ov, 3);
      cyc();

      // ---- stop on the 10th RUN cycle of a 100-sample sweep ----
      start = 1'b1; step = 32'd1000; num_samples = 16'd100;
      cyc();                                   // RUN cycle 1
      start = 1'b0;
      n_av = 0;
      for (int i = 0; i < 9; i++) begin
         if (angle_valid) n_av++;
         cyc();
      end
      chk("s_av_count", n_av, 9);
      stop = 1'b1;
      #1;
      chk("s_valid_at_stop", angle_valid, 0);
      cyc();
      stop = 1'b0;
      chk("s_busy_drain", busy, 1);
      run_out(60, n_ov, n_av, got_done, ov_done);
      chk("s_done_seen", got_done, 1);
      chk("s_ov_count", n_ov, 9);
      chk("s_ov_at_done", ov_done, 1);
      chk("s_no_av_drain", n_av, 0);
      cyc();
      chk("s_idle", busy, 0);

      // ---- stop on the very first RUN cycle ----
      start = 1'b1; stop = 1'b1; step = 32'd7; num_samples = 16'd5;
      cyc();
      start = 1'b0;
      chk("i_busy", busy, 1);
      chk("i_valid", angle_valid, 0);
      cyc();
      stop = 1'b0;
      chk("i_done", done, 1);
      chk("i_ov", out_valid, 0);
      chk("i_busy_drain", busy, 1);
      cyc();
      chk("i_done_pulse", done, 0);
      chk("i_busy_idle", busy, 0);

      // ---- asynchronous reset mid-sweep ----
      start = 1'b1; step = 32'd268435456; num_samples = 16'd50;
      cyc();
      start = 1'b0;
      repeat (20) cyc();
      chk("a_idx_before", sample_idx, 20);
      #1;
      rst = 1'b1;
      #1;
      chk("a_angle", angle, 0);
      chk("a_valid", angle_valid, 0);
      chk("a_idx", sample_idx, 0);
      chk("a_busy", busy, 0);
      chk("a_ov", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      any_bad = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (out_valid || done || angle_valid) any_bad++;
      end
      chk("a_quiet_after_reset", any_bad, 0);
      start = 1'b1; step = 32'd5; num_samples = 16'd2;
      cyc();
      start = 1'b0;
      chk("a_new_angle0", angle, 0);
      chk("a_new_valid", angle_valid, 1);
      cyc();
      chk("a_new_angle1", angle, 5);
      chk("a_new_idx1", sample_idx, 1);
      cyc();
      run_out(60, n_ov, n_av, got_done, ov_done);
      chk("a_new_done", got_done, 1);
      chk("a_new_ov_count", n_ov, 2);
      cyc();

      // ---- zero-length sweep ----
      start = 1'b1; step = 32'd100; num_samples = 16'd0;
      cyc();
      start = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_valid", angle_valid, 0);
      any_bad = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (out_valid || busy || angle_valid || done) any_bad++;
      end
      chk("z_quiet", any_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
